// File: rtl/icache_pkg.sv
// Shared constants, state encoding and address helpers for the instruction-cache refill engine.
// Optional feature macro: CRITICAL_WORD_FIRST_EN (see icache_refill.sv).
package icache_pkg;

  localparam int ADDR_W         = 16;
  localparam int WORD_W         = 16;
  localparam int WORDS_PER_LINE = 4;
  localparam int LINE_W         = WORD_W * WORDS_PER_LINE;
  localparam int OFFSET_BITS    = 3;
  localparam int IDX_W          = $clog2(WORDS_PER_LINE);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE,
    SETTLE
  } refill_state_t;

  function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  endfunction

  // Bit 0 of a fetch address is a byte offset inside a 16-bit word and never selects a word.
  function automatic logic [IDX_W-1:0] word_index(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_BITS-1:1];
  endfunction

  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [IDX_W-1:0]  idx);
    return base + ADDR_W'({idx, 1'b0});
  endfunction

endpackage

// File: rtl/icache_refill_if.sv
// Fetch, memory and cache-fill signals of the refill engine, bundled as one interface.
// Optional feature macro: CRITICAL_WORD_FIRST_EN adds out_cw_vld.
interface icache_refill_if;
  import icache_pkg::*;

  logic [ADDR_W-1:0] inp_address;
  logic              inp_fetch_vld;
  logic              inp_hit;
  logic              out_stall;

  logic              out_mem_req;
  logic [ADDR_W-1:0] out_mem_addr;
  logic              inp_mem_ready;
  logic [WORD_W-1:0] inp_mem_data;

  logic [LINE_W-1:0] out_lineData;
  logic              out_fill;
  logic [ADDR_W-1:0] out_fill_addr;
`ifdef CRITICAL_WORD_FIRST_EN
  logic              out_cw_vld;
`endif

  // Refill engine side.
  modport master (
    input  inp_address, inp_fetch_vld, inp_hit, inp_mem_ready, inp_mem_data,
    output out_stall, out_mem_req, out_mem_addr, out_lineData, out_fill, out_fill_addr
`ifdef CRITICAL_WORD_FIRST_EN
    , output out_cw_vld
`endif
  );

  // Fetch stage / memory / cache side.
  modport slave (
    output inp_address, inp_fetch_vld, inp_hit, inp_mem_ready, inp_mem_data,
    input  out_stall, out_mem_req, out_mem_addr, out_lineData, out_fill, out_fill_addr
`ifdef CRITICAL_WORD_FIRST_EN
    , input out_cw_vld
`endif
  );

endinterface

// File: rtl/icache_line_buf.sv
// Four-word line assembly buffer: one indexed write port, flat 64-bit read, async active-low clear.
module icache_line_buf
  import icache_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [WORD_W-1:0] wr_data,
  output logic [LINE_W-1:0] line_data
);

  for (genvar gi = 0; gi < WORDS_PER_LINE; gi++) begin : g_word
    logic [WORD_W-1:0] word_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        word_reg <= '0;
      end else if (wr_en && (wr_idx == IDX_W'(gi))) begin
        word_reg <= wr_data;
      end
    end

    assign line_data[gi*WORD_W +: WORD_W] = word_reg;
  end

endmodule

// File: rtl/icache_refill.sv
// Instruction-cache miss engine: fetches a 4-beat line from 16-bit memory and pulses one fill write.
// Optional feature macro: CRITICAL_WORD_FIRST_EN (start the burst at the missed word, wrap in-line).
module icache_refill
  import icache_pkg::*;
(
  input  logic            inp_clk,
  input  logic            inp_rst_n,
  icache_refill_if.master bus
);

  refill_state_t     state_reg, state_next;
  logic [ADDR_W-1:0] base_reg, base_next;
  logic [IDX_W-1:0]  beat_reg, beat_next;
  logic [IDX_W-1:0]  word_idx;
  logic [LINE_W-1:0] line_flat;

  logic              miss;
  logic              accept;
  logic              stall;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              fill;
  logic [ADDR_W-1:0] fill_addr;

`ifdef CRITICAL_WORD_FIRST_EN
  logic [IDX_W-1:0]  start_reg, start_next;
  logic              cw_vld_reg;

  // beat_reg counts accepted beats; the word slot wraps inside the line from the missed word.
  assign word_idx = start_reg + beat_reg;
`else
  assign word_idx = beat_reg;
`endif

  assign miss   = bus.inp_fetch_vld & ~bus.inp_hit;
  assign accept = (state_reg == FILL) & bus.inp_mem_ready;

  always_ff @(posedge inp_clk or negedge inp_rst_n) begin
    if (!inp_rst_n) begin
      state_reg <= IDLE;
      base_reg  <= '0;
      beat_reg  <= '0;
    end else begin
      state_reg <= state_next;
      base_reg  <= base_next;
      beat_reg  <= beat_next;
    end
  end

`ifdef CRITICAL_WORD_FIRST_EN
  // cw_vld rises in the cycle after the first beat lands, when that word is readable on out_lineData.
  always_ff @(posedge inp_clk or negedge inp_rst_n) begin
    if (!inp_rst_n) begin
      start_reg  <= '0;
      cw_vld_reg <= 1'b0;
    end else begin
      start_reg  <= start_next;
      cw_vld_reg <= accept && (beat_reg == '0);
    end
  end
`endif

  always_comb begin
    state_next = state_reg;
    base_next  = base_reg;
    beat_next  = beat_reg;
`ifdef CRITICAL_WORD_FIRST_EN
    start_next = start_reg;
`endif
    stall      = 1'b0;
    mem_req    = 1'b0;
    mem_addr   = '0;
    fill       = 1'b0;
    fill_addr  = '0;

    unique case (state_reg)
      IDLE: begin
        stall = miss;
        if (miss) begin
          base_next  = line_base(bus.inp_address);
          beat_next  = '0;
`ifdef CRITICAL_WORD_FIRST_EN
          start_next = word_index(bus.inp_address);
`endif
          state_next = FILL;
        end
      end

      FILL: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = word_addr(base_reg, word_idx);
        if (bus.inp_mem_ready) begin
          beat_next = beat_reg + IDX_W'(1);
          if (beat_reg == IDX_W'(WORDS_PER_LINE - 1)) begin
            state_next = WRITE;
          end
        end
      end

      WRITE: begin
        stall      = 1'b1;
        fill       = 1'b1;
        fill_addr  = base_reg;
        state_next = SETTLE;
      end

      // The cache needs one cycle after the write before its hit flag reflects the new line.
      SETTLE: begin
        stall      = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  icache_line_buf u_line_buf (
    .clk       (inp_clk),
    .rst_n     (inp_rst_n),
    .wr_en     (accept),
    .wr_idx    (word_idx),
    .wr_data   (bus.inp_mem_data),
    .line_data (line_flat)
  );

  assign bus.out_stall     = stall;
  assign bus.out_mem_req   = mem_req;
  assign bus.out_mem_addr  = mem_addr;
  assign bus.out_fill      = fill;
  assign bus.out_fill_addr = fill_addr;
  assign bus.out_lineData  = line_flat;
`ifdef CRITICAL_WORD_FIRST_EN
  assign bus.out_cw_vld    = cw_vld_reg;
`endif

endmodule

// File: tb/tb_icache_refill.sv
// Scoreboard bench for icache_refill: random misses against a line-level reference model.
// Honours CRITICAL_WORD_FIRST_EN when the design is built with it.
module tb_icache_refill;

  typedef struct {
    logic [15:0] addr;
    bit          first;
    int          word;
  } beat_t;

  typedef struct {
    logic [15:0] addr;
    logic [63:0] line;
    int          cyc;
  } fill_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  int   mem_mode;
  bit   tog;

  logic [15:0] mem [0:32767];
  beat_t       exp_beat_q [$];
  fill_t       exp_fill_q [$];

  icache_refill_if bus ();

  icache_refill dut (
    .inp_clk   (clk),
    .inp_rst_n (rst_n),
    .bus       (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] ref_line(input logic [15:0] base);
    logic [63:0] l;
    for (int k = 0; k < 4; k++) l[16*k +: 16] = mem[base[15:1] + 15'(k)];
    return l;
  endfunction

  function automatic int first_word(input logic [15:0] addr);
`ifdef CRITICAL_WORD_FIRST_EN
    return int'(addr[2:1]);
`else
    return 0;
`endif
  endfunction

  // Reference: a miss at addr reads the 8-byte line around addr, starting at first_word and
  // wrapping within the line, then writes that line once at its base.
  task automatic push_expect(input logic [15:0] addr, input int fill_cyc);
    logic [15:0] base;
    beat_t b;
    fill_t f;
    base = addr & 16'hFFF8;
    for (int k = 0; k < 4; k++) begin
      b.word  = (first_word(addr) + k) % 4;
      b.addr  = base + 16'(2 * b.word);
      b.first = (k == 0);
      exp_beat_q.push_back(b);
    end
    f.addr = base;
    f.line = ref_line(base);
    f.cyc  = fill_cyc;
    exp_fill_q.push_back(f);
  endtask

  // Memory: mode 0 zero-wait, 1 toggling ready, 2 random ready (also outside requests).
  initial begin
    tog = 1'b0;
    bus.inp_mem_ready = 1'b0;
    bus.inp_mem_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      tog = ~tog;
      case (mem_mode)
        0:       bus.inp_mem_ready = 1'b1;
        1:       bus.inp_mem_ready = tog;
        default: bus.inp_mem_ready = 1'($urandom_range(0, 1));
      endcase
      bus.inp_mem_data = bus.out_mem_req ? mem[bus.out_mem_addr[15:1]] : 16'($urandom);
    end
  end

  // Monitor: pops the scoreboard whenever the DUT accepts a beat or pulses a fill.
  initial begin
    bit          cw_pending;
    bit          exp_cw;
    int          cw_word;
    logic [15:0] cw_data;
    beat_t       b;
    fill_t       f;
    cw_pending = 1'b0;
    cw_word    = 0;
    cw_data    = '0;
    forever begin
      @(negedge clk);
      exp_cw     = cw_pending;
      cw_pending = 1'b0;
      if (rst_n) begin
`ifdef CRITICAL_WORD_FIRST_EN
        chk("cw_vld", 64'(bus.out_cw_vld), 64'(exp_cw));
        if (exp_cw) chk("cw_word", 64'(bus.out_lineData[16*cw_word +: 16]), 64'(cw_data));
`endif
        if (bus.out_mem_req) begin
          if (exp_beat_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_req addr=%h required=no request", bus.out_mem_addr);
          end else begin
            b = exp_beat_q[0];
            if (bus.inp_mem_ready) begin
              void'(exp_beat_q.pop_front());
              chk("beat_addr", 64'(bus.out_mem_addr), 64'(b.addr));
              $display("beat  cyc=%0d addr=%h data=%h", cyc, bus.out_mem_addr, bus.inp_mem_data);
              if (b.first) begin
                cw_pending = 1'b1;
                cw_word    = b.word;
                cw_data    = mem[b.addr[15:1]];
              end
            end else begin
              chk("hold_addr", 64'(bus.out_mem_addr), 64'(b.addr));
            end
          end
        end
        if (bus.out_fill) begin
          if (exp_fill_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_fill addr=%h required=no fill", bus.out_fill_addr);
          end else begin
            f = exp_fill_q.pop_front();
            $display("fill  cyc=%0d addr=%h line=%h", cyc, bus.out_fill_addr, bus.out_lineData);
            chk("fill_addr", 64'(bus.out_fill_addr), 64'(f.addr));
            chk("fill_line", bus.out_lineData, f.line);
            if (f.cyc >= 0) chk("fill_cycle", 64'(cyc), 64'(f.cyc));
          end
        end
      end
    end
  end

  // Fetch stage + cache model: presents a miss, holds it until the fill, then shows a hit.
  task automatic run_miss(input logic [15:0] addr, input int mode, input int chg_at, input int hit_at);
    int n;
    bit seen;
    mem_mode = mode;
    @(posedge clk);
    #1;
    push_expect(addr, (mode == 0) ? cyc + 5 : -1);
    bus.inp_address   = addr;
    bus.inp_fetch_vld = 1'b1;
    bus.inp_hit       = 1'b0;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 300) begin
      @(negedge clk);
      chk("stall_busy", 64'(bus.out_stall), 64'(1));
      if (bus.out_fill) begin
        seen = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        n++;
        if (n == chg_at) bus.inp_address = 16'h0100;
        if (n == hit_at) bus.inp_hit = 1'b1;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL fill_timeout miss=%h waited=%0d cycles required=fill pulse", addr, n);
    end
    @(posedge clk);
    #1;
    bus.inp_hit = 1'b1;
    @(negedge clk);
    chk("stall_settle", 64'(bus.out_stall), 64'(1));
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("stall_release", 64'(bus.out_stall), 64'(0));
    @(posedge clk);
    #1;
    bus.inp_fetch_vld = 1'b0;
    bus.inp_hit       = 1'b0;
    bus.inp_address   = 16'($urandom);
  endtask

  task automatic reset_mid_fill();
    int nacc;
    int n;
    mem_mode = 0;
    @(posedge clk);
    #1;
    push_expect(16'h0042, cyc + 5);
    bus.inp_address   = 16'h0042;
    bus.inp_fetch_vld = 1'b1;
    bus.inp_hit       = 1'b0;
    nacc = 0;
    n    = 0;
    while (nacc < 2 && n < 50) begin
      @(negedge clk);
      if (bus.out_mem_req && bus.inp_mem_ready) nacc++;
      n++;
      @(posedge clk);
      #1;
    end
    if (nacc < 2) begin
      checks++;
      errors++;
      $display("FAIL reset_setup accepted=%0d required=2 beats", nacc);
    end
    rst_n             = 1'b0;
    bus.inp_fetch_vld = 1'b0;
    #1;
    chk("rst_req", 64'(bus.out_mem_req), 64'(0));
    chk("rst_fill", 64'(bus.out_fill), 64'(0));
    chk("rst_line", bus.out_lineData, 64'(0));
    chk("rst_stall", 64'(bus.out_stall), 64'(0));
    exp_beat_q.delete();
    exp_fill_q.delete();
    $display("reset asserted mid-fill after %0d beats", nacc);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_fill", 64'(bus.out_fill), 64'(0));
      chk("post_rst_req", 64'(bus.out_mem_req), 64'(0));
    end
  endtask

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog cycle=%0d required=bench completion", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    checks   = 0;
    errors   = 0;
    mem_mode = 0;
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    mem[0] = 16'hF000;
    mem[1] = 16'hFF00;
    mem[2] = 16'hFFF0;
    mem[3] = 16'hFFFF;
    rst_n             = 1'b0;
    bus.inp_address   = '0;
    bus.inp_fetch_vld = 1'b0;
    bus.inp_hit       = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset_stall", 64'(bus.out_stall), 64'(0));
    chk("reset_req", 64'(bus.out_mem_req), 64'(0));
    chk("reset_mem_addr", 64'(bus.out_mem_addr), 64'(0));
    chk("reset_fill", 64'(bus.out_fill), 64'(0));
    chk("reset_fill_addr", 64'(bus.out_fill_addr), 64'(0));
    chk("reset_line", bus.out_lineData, 64'(0));
`ifdef CRITICAL_WORD_FIRST_EN
    chk("reset_cw_vld", 64'(bus.out_cw_vld), 64'(0));
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_miss(16'h0000, 0, -1, -1);          // known line, zero-wait latency
    chk("known_line", bus.out_lineData, 64'hFFFF_FFF0_FF00_F000);
    run_miss(16'h000A, 1, -1, -1);          // toggling ready
    run_miss(16'hFFFE, 2, -1, 2);           // top of memory, hit rises mid-fill
    reset_mid_fill();
    run_miss(16'h0235, 1, 2, -1);           // address moves mid-fill, odd address
`ifdef CRITICAL_WORD_FIRST_EN
    run_miss(16'h0006, 0, -1, -1);          // critical word first
    chk("cwf_line", bus.out_lineData, 64'hFFFF_FFF0_FF00_F000);
`endif
    for (int i = 0; i < 24; i++) begin
      run_miss(16'($urandom), int'($urandom_range(0, 2)),
               ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 5)) : -1,
               ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 5)) : -1);
    end

    repeat (3) @(negedge clk);
    chk("beats_drained", 64'(exp_beat_q.size()), 64'(0));
    chk("fills_drained", 64'(exp_fill_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
